core_inst_seq: RTL and testbench
================================

# core_inst_seq

Instruction sequencer for one 8x8 tile pass of the systolic `core`. After a `start` pulse it drives the 47-bit `inst` bus cycle by cycle. It loads `col` weight words from weight SRAM into L0 and loads the kernel into the array. It then streams `x_len` activation words into L0 and executes them. Finally it drains the OFIFO into psum SRAM, pulses `done` and returns to idle. It sits directly above `core` and owns every `inst` bit except `inst[33]` (SFP valid), which it holds at 0.

## Interface
- `row`, default 8: PE rows; also the L0 width in words.
- `col`, default 8: PE columns; weight words loaded per tile.
- `addr_bw`, default 11: SRAM address width.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: request a tile pass. Sampled only in IDLE.
- `w_base` input, `addr_bw` bits: first weight SRAM address.
- `x_base` input, `addr_bw` bits: first activation SRAM address.
- `p_base` input, `addr_bw` bits: first psum SRAM address.
- `x_len` input, `addr_bw` bits: number of activation vectors, 1..2047.
- `ofifo_valid` input, 1 bit: OFIFO holds at least one output vector.
- `inst` output, 47 bits: core instruction; the field map is under Operation.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse at the end of a pass.

## Operation
**Registered inputs**
- `w_base`, `x_base`, `p_base` and `x_len` are captured on the accepting edge and held for the whole pass.

**`inst` fields.** SRAM CEN/WEN are active-low.
- [0] kernel load.
- [1] execute.
- [2] L0 write from activation SRAM.
- [4] L0 read during kernel load.
- [3] L0 read during execute.
- [5] L0 write from weight SRAM.
- [6] OFIFO read.
- Weight SRAM: A [17:7], WEN [18], CEN [19].
- Psum SRAM: A [30:20], WEN [31], CEN [32].
- [33] SFP valid, held at 0.
- Activation SRAM: A [44:34], WEN [45], CEN [46].

**Idle value**
- Bits 46, 45, 32, 31, 19, 18 = 1; all other bits 0.
- `inst` is registered. Every state drives the idle value except for the fields named below.

**FSM** (a counter `k` restarts at 0 on every state entry):
- IDLE: on `start`=1 with `x_len`≠0, go to WLOAD. `start` with `x_len`=0 is ignored.
- WLOAD, `col`+1 cycles:
  - For `k` < `col`: weight CEN=0, WEN=1, A=`w_base`+`k`.
  - For `k` ≥ 1: [5]=1. SRAM read latency is 1, so each L0 write lands one cycle after its read.
- KLOAD, `col` cycles: [0]=1, [4]=1.
- KWAIT, `row`+`col` cycles: idle value, to let the kernel propagate.
- XLOAD, `x_len`+1 cycles, same pattern as WLOAD:
  - For `k` < `x_len`: activation CEN=0, WEN=1, A=`x_base`+`k`.
  - For `k` ≥ 1: [2]=1.
- EXEC, `x_len` cycles: [1]=1, [3]=1.
- DRAIN, until `x_len` words have been written:
  - In any cycle where `ofifo_valid`=1 and reads issued < `x_len`: [6]=1.
  - In the cycle after each read: psum CEN=0, WEN=0, A=`p_base`+`j`, where `j` counts completed writes.
  - Read and write may overlap in the same cycle.
  - Leave DRAIN after the `x_len`-th write.
- DONE, 1 cycle: `done`=1, then go to IDLE.

**Arithmetic**
- All address sums are `addr_bw` wide and wrap modulo 2^`addr_bw`. Example: `x_base`=2046, `x_len`=3 addresses 2046, 2047, 0.

**Boundary rules**
- `start` while `busy` is ignored.
- `ofifo_valid` outside DRAIN is ignored.
- In DRAIN, no OFIFO read is issued once reads issued = `x_len`, even if `ofifo_valid` stays high.
- The pass stalls in DRAIN indefinitely while `ofifo_valid`=0; there is no timeout.

## Timing
- Asynchronous reset forces: state IDLE, all counters 0, `inst` = idle value, `busy`=0, `done`=0.
- Reset asserted mid-pass aborts the pass immediately. No `done` pulse is produced for the aborted pass.
- Handshake: `start` is accepted on edge E0. `busy` and the first WLOAD `inst` are visible after E0.
- Fixed latency from accept to DRAIN entry: (`col`+1) + `col` + (`row`+`col`) + (`x_len`+1) + `x_len` cycles. With defaults and `x_len`=4 this is 9+8+16+5+4 = 42.
- With `ofifo_valid` held at 1, DRAIN takes `x_len`+1 cycles. `done` is high in the cycle after the last psum write. `busy` falls together with `done`.

## Test plan
- Reset: hold `reset` high for 3 cycles, then release -> `inst` = idle value (bits 46, 45, 32, 31, 19, 18 set), `busy`=0, `done`=0.
- Defaults, `w_base`=16, `x_base`=100, `p_base`=200, `x_len`=4, `ofifo_valid` tied to 1:
  - Weight addresses 16..23 appear on consecutive cycles, with [5] lagging each by 1 cycle.
  - Activation addresses 100..103 appear, with [2] lagging each by 1.
  - Psum writes go to 200..203.
  - `done` pulses exactly 47 cycles after accept.
- DRAIN stall: toggle `ofifo_valid` 1,0,0,1,1,0,1 with `x_len`=4 -> exactly 4 [6] pulses, each followed next cycle by a psum write at 200..203 in order. No 5th read is issued.
- Address wrap: `x_base`=2046, `x_len`=3 -> activation A sequence 2046, 2047, 0.
- Ignored requests: pulse `start` mid-EXEC -> no restart and no second `done`. `start` with `x_len`=0 in IDLE -> `busy` stays 0.
- Reset mid-pass: assert `reset` during XLOAD -> `inst` returns to the idle value asynchronously. A following `start` runs a complete pass.

Source files
------------

// File: rtl/core_inst_seq_if.sv
// Control/status bundle between a tile-pass requester and the core instruction sequencer.
// The requester side is the master; the sequencer is the slave.
interface core_inst_seq_if #(
    parameter int addr_bw = 11
);
    logic               start;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [addr_bw-1:0] p_base;
    logic [addr_bw-1:0] x_len;
    logic               ofifo_valid;
    logic [46:0]        inst;
    logic               busy;
    logic               done;

    modport master (
        output start, w_base, x_base, p_base, x_len, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, w_base, x_base, p_base, x_len, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_inst_seq.sv
// Sequences one 8x8 tile pass of the systolic core: weight load, kernel load,
// activation load, execute and OFIFO drain into psum SRAM, all via the registered inst bus.
//
// state | meaning
// IDLE  | waiting for start with nonzero x_len
// WLOAD | weight SRAM reads into L0, col+1 cycles
// KLOAD | L0 to array kernel load, col cycles
// KWAIT | kernel propagation, row+col cycles
// XLOAD | activation SRAM reads into L0, x_len+1 cycles
// EXEC  | execute with L0 read, x_len cycles
// DRAIN | OFIFO reads followed by psum SRAM writes
// DONE  | one-cycle done pulse
module core_inst_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic            clk,
    input  logic            reset,
    core_inst_seq_if.slave  bus
);
    localparam int CW = addr_bw + 1;

    localparam logic [46:0] IDLE_INST = (47'd1 << 46) | (47'd1 << 45) | (47'd1 << 32) |
                                        (47'd1 << 31) | (47'd1 << 19) | (47'd1 << 18);
    localparam logic [46:0] KLOAD_INST = IDLE_INST | 47'h11;
    localparam logic [46:0] EXEC_INST  = IDLE_INST | 47'h0A;

    localparam logic [CW-1:0] COL_K      = CW'(col);
    localparam logic [CW-1:0] KLOAD_LAST = CW'(col - 1);
    localparam logic [CW-1:0] KWAIT_LAST = CW'(row + col - 1);

    typedef enum logic [2:0] {IDLE, WLOAD, KLOAD, KWAIT, XLOAD, EXEC, DRAIN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      k;
    logic [addr_bw-1:0] w_base_r, x_base_r, p_base_r, x_len_r;
    logic [CW-1:0]      rd_cnt, wr_cnt;
    logic               rd_now, wr_now;
    logic [46:0]        inst_r;
    logic               busy_r, done_r;

    logic [CW-1:0]      len_k;
    logic               rd_go;

    assign len_k    = {1'b0, x_len_r};
    assign rd_go    = bus.ofifo_valid && (rd_cnt < len_k);
    assign bus.inst = inst_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Shared pattern of WLOAD/XLOAD: SRAM read while kk < len, L0 write one cycle behind.
    function automatic logic [46:0] load_inst(input logic act, input logic [CW-1:0] kk,
                                              input logic [CW-1:0] len,
                                              input logic [addr_bw-1:0] base);
        logic [46:0]        v;
        logic [addr_bw-1:0] a;
        v = IDLE_INST;
        a = base + kk[addr_bw-1:0];
        if (kk < len) begin
            if (act) begin
                v[46]    = 1'b0;
                v[44:34] = a;
            end else begin
                v[19]    = 1'b0;
                v[17:7]  = a;
            end
        end
        if (kk != '0) begin
            if (act) v[2] = 1'b1;
            else     v[5] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [46:0] drain_inst(input logic rd, input logic wr,
                                               input logic [addr_bw-1:0] a);
        logic [46:0] v;
        v    = IDLE_INST;
        v[6] = rd;
        if (wr) begin
            v[32]    = 1'b0;
            v[31]    = 1'b0;
            v[30:20] = a;
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            w_base_r <= '0;
            x_base_r <= '0;
            p_base_r <= '0;
            x_len_r  <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            rd_now   <= 1'b0;
            wr_now   <= 1'b0;
            inst_r   <= IDLE_INST;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.x_len != '0)) begin
                        w_base_r <= bus.w_base;
                        x_base_r <= bus.x_base;
                        p_base_r <= bus.p_base;
                        x_len_r  <= bus.x_len;
                        state    <= WLOAD;
                        k        <= '0;
                        busy_r   <= 1'b1;
                        inst_r   <= load_inst(1'b0, '0, COL_K, bus.w_base);
                    end
                end
                WLOAD: begin
                    if (k == COL_K) begin
                        state  <= KLOAD;
                        k      <= '0;
                        inst_r <= KLOAD_INST;
                    end else begin
                        k      <= k + 1'b1;
                        inst_r <= load_inst(1'b0, k + 1'b1, COL_K, w_base_r);
                    end
                end
                KLOAD: begin
                    if (k == KLOAD_LAST) begin
                        state  <= KWAIT;
                        k      <= '0;
                        inst_r <= IDLE_INST;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                KWAIT: begin
                    if (k == KWAIT_LAST) begin
                        state  <= XLOAD;
                        k      <= '0;
                        inst_r <= load_inst(1'b1, '0, len_k, x_base_r);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                XLOAD: begin
                    if (k == len_k) begin
                        state  <= EXEC;
                        k      <= '0;
                        inst_r <= EXEC_INST;
                    end else begin
                        k      <= k + 1'b1;
                        inst_r <= load_inst(1'b1, k + 1'b1, len_k, x_base_r);
                    end
                end
                EXEC: begin
                    if (k == len_k - 1'b1) begin
                        // First DRAIN cycle may already read the OFIFO.
                        state  <= DRAIN;
                        k      <= '0;
                        rd_now <= bus.ofifo_valid;
                        rd_cnt <= {{(CW-1){1'b0}}, bus.ofifo_valid};
                        wr_cnt <= '0;
                        wr_now <= 1'b0;
                        inst_r <= drain_inst(bus.ofifo_valid, 1'b0, '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (wr_now && (wr_cnt == len_k)) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        rd_now <= 1'b0;
                        wr_now <= 1'b0;
                        inst_r <= IDLE_INST;
                    end else begin
                        // wr_cnt counts writes issued, so it addresses the next one.
                        rd_now <= rd_go;
                        wr_now <= rd_now;
                        if (rd_go)  rd_cnt <= rd_cnt + 1'b1;
                        if (rd_now) wr_cnt <= wr_cnt + 1'b1;
                        inst_r <= drain_inst(rd_go, rd_now, p_base_r + wr_cnt[addr_bw-1:0]);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: stimulus pushes expected SRAM addresses and done
// timing into queues, a negedge monitor pops and compares as the DUT presents them.
module tb_core_inst_seq;
    localparam logic [46:0] IDLE_V = 47'h6001_800C_0000;

    typedef struct {
        int cyc;
        int nrd;
        int nk;
        int nx;
    } done_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    int    exp_w[$];
    int    exp_x[$];
    int    exp_p[$];
    done_t exp_d[$];

    core_inst_seq_if #(.addr_bw(11)) bus ();

    core_inst_seq #(.row(8), .col(8), .addr_bw(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic prev_wr = 1'b0, prev_xr = 1'b0, prev_rd = 1'b0;
    int   nrd = 0, nk = 0, nx = 0;

    always @(negedge clk) begin
        logic wr, xr, pw, rd;
        done_t d;
        if (reset) begin
            prev_wr = 1'b0; prev_xr = 1'b0; prev_rd = 1'b0;
            nrd = 0; nk = 0; nx = 0;
        end else begin
            wr = !bus.inst[19];
            xr = !bus.inst[46];
            pw = !bus.inst[32];
            rd = bus.inst[6];
            if (wr) begin
                chk("w_read_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) chk("w_addr", bus.inst[17:7], exp_w.pop_front());
                chk("w_wen", bus.inst[18], 1);
            end
            if (wr || prev_wr) chk("l0_w_lag", bus.inst[5], prev_wr);
            if (xr) begin
                chk("x_read_expected", exp_x.size() > 0, 1);
                if (exp_x.size() > 0) chk("x_addr", bus.inst[44:34], exp_x.pop_front());
                chk("x_wen", bus.inst[45], 1);
            end
            if (xr || prev_xr) chk("l0_x_lag", bus.inst[2], prev_xr);
            if (pw) begin
                chk("p_write_expected", exp_p.size() > 0, 1);
                if (exp_p.size() > 0) chk("p_addr", bus.inst[30:20], exp_p.pop_front());
                chk("p_wen", bus.inst[31], 0);
            end
            if (pw || prev_rd) chk("psum_after_read", pw, prev_rd);
            if (rd) nrd++;
            if (bus.inst[0] && bus.inst[4]) nk++;
            if (bus.inst[1] && bus.inst[3]) nx++;
            if (bus.done) begin
                chk("done_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) begin
                    d = exp_d.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("ofifo_reads", nrd, d.nrd);
                    chk("kload_cycles", nk, d.nk);
                    chk("exec_cycles", nx, d.nx);
                end
                chk("busy_in_done", bus.busy, 1);
                chk("inst_at_done", bus.inst, IDLE_V);
                nrd = 0; nk = 0; nx = 0;
            end
            prev_wr = wr; prev_xr = xr; prev_rd = rd;
        end
    end

    // Stimulus helpers
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_seq(input int base, input int n, inout int q[$]);
        for (int i = 0; i < n; i++) q.push_back((base + i) % 2048);
    endtask

    task automatic start_pass(input int wb, input int xb, input int pb, input int xl,
                              output int acc);
        bus.w_base = 11'(wb);
        bus.x_base = 11'(xb);
        bus.p_base = 11'(pb);
        bus.x_len  = 11'(xl);
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while ((exp_d.size() + exp_w.size() + exp_x.size() + exp_p.size()) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_completed"}, n < 300, 1);
        exp_d.delete(); exp_w.delete(); exp_x.delete(); exp_p.delete();
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_idle_after"}, bus.busy, 0);
    endtask

    int    acc;
    done_t d;
    int    pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        bus.start = 1'b0;
        bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.x_len = '0;
        bus.ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_inst", bus.inst, IDLE_V);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);

        // Basic pass, ofifo_valid tied high
        bus.ofifo_valid = 1'b1;
        push_seq(16, 8, exp_w);
        push_seq(100, 4, exp_x);
        push_seq(200, 4, exp_p);
        start_pass(16, 100, 200, 4, acc);
        chk("busy_after_accept", bus.busy, 1);
        d = '{cyc: acc + 47, nrd: 4, nk: 8, nx: 4};
        exp_d.push_back(d);
        wait_clear("basic");

        // DRAIN stall with toggled ofifo_valid, then held high
        bus.ofifo_valid = 1'b0;
        push_seq(16, 8, exp_w);
        push_seq(100, 4, exp_x);
        push_seq(200, 4, exp_p);
        start_pass(16, 100, 200, 4, acc);
        d = '{cyc: acc + 50, nrd: 4, nk: 8, nx: 4};
        exp_d.push_back(d);
        for (int i = 0; i < 7; i++) begin
            goto(acc + 41 + i);
            bus.ofifo_valid = pat[i][0];
        end
        goto(acc + 48);
        bus.ofifo_valid = 1'b1;
        wait_clear("stall");

        // Activation address wrap
        push_seq(0, 8, exp_w);
        exp_x.push_back(2046); exp_x.push_back(2047); exp_x.push_back(0);
        push_seq(5, 3, exp_p);
        start_pass(0, 2046, 5, 3, acc);
        d = '{cyc: acc + 44, nrd: 3, nk: 8, nx: 3};
        exp_d.push_back(d);
        wait_clear("wrap");

        // start during EXEC ignored; weight address wrap
        exp_w.push_back(2040); exp_w.push_back(2041); exp_w.push_back(2042); exp_w.push_back(2043);
        exp_w.push_back(2044); exp_w.push_back(2045); exp_w.push_back(2046); exp_w.push_back(2047);
        push_seq(300, 2, exp_x);
        push_seq(2047, 2, exp_p);
        start_pass(2040, 300, 2047, 2, acc);
        d = '{cyc: acc + 41, nrd: 2, nk: 8, nx: 2};
        exp_d.push_back(d);
        goto(acc + 36);
        bus.start = 1'b1;
        goto(acc + 37);
        bus.start = 1'b0;
        wait_clear("start_mid_exec");
        repeat (60) @(posedge clk);
        #1;
        chk("no_restart_busy", bus.busy, 0);

        // start with x_len=0 ignored
        bus.x_len = '0;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("zero_len_busy", bus.busy, 0);
        end
        bus.start = 1'b0;

        // Reset during XLOAD aborts, then a full pass runs
        push_seq(16, 8, exp_w);
        exp_x.push_back(100);
        start_pass(16, 100, 200, 4, acc);
        goto(acc + 34);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_inst", bus.inst, IDLE_V);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_queues_drained", exp_w.size() + exp_x.size(), 0);
        exp_w.delete(); exp_x.delete();
        push_seq(16, 8, exp_w);
        push_seq(100, 4, exp_x);
        push_seq(200, 4, exp_p);
        start_pass(16, 100, 200, 4, acc);
        d = '{cyc: acc + 47, nrd: 4, nk: 8, nx: 4};
        exp_d.push_back(d);
        wait_clear("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
